// File: rtl/unsat_index_mapper_pkg.sv
// Shared types, width helpers and reciprocal-table rule for the unsat index mapper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package unsat_index_mapper_pkg;

   // Name of the hex image holding the reciprocal table.
   localparam M_TABLE_NAME_DEFAULT = "M_table_roundup.mem";

   // Width of the unsat count port: must hold 0..depth inclusive.
   function automatic int count_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   // Width of the returned buffer index: 0..depth-1.
   function automatic int index_width(input int depth);
      return $clog2(depth);
   endfunction

   // Request classification carried alongside each pipeline stage.
   typedef struct packed {
      logic is_one;
      logic is_zero;
   } req_flags_t;

   // Reciprocal entry for address idx: ceil(2^frac_bits / (idx+1)).
   // Address 0 (m=1) would need frac_bits+1 bits, so it saturates to all-ones.
   function automatic logic [63:0] recip_entry(input int idx, input int frac_bits);
      logic [63:0] one_scaled;
      one_scaled = 64'd1 << frac_bits;
      if (idx == 0) begin
         return one_scaled - 64'd1;
      end
      return (one_scaled + 64'(idx)) / 64'(idx + 1);
   endfunction

endpackage

// File: rtl/unsat_index_mapper_if.sv
// Request/result handshake bundle between the RNG side, the mapper and the buffer read port.
// Latency: n/a (wires only).
// Backpressure: in_ready/out_ready carried here; master drives requests and consumes results.
interface unsat_index_mapper_if #(
   parameter int RAND_WIDTH   = 32,
   parameter int BUFFER_DEPTH = 2048
) ();
   import unsat_index_mapper_pkg::*;

   localparam int CW = count_width(BUFFER_DEPTH);
   localparam int IW = index_width(BUFFER_DEPTH);

   logic                  in_valid;
   logic                  in_ready;
   logic [RAND_WIDTH-1:0] in_rand;
   logic [CW-1:0]         in_count;
   logic                  out_valid;
   logic                  out_ready;
   logic [IW-1:0]         out_idx;
   logic                  out_err;

   // Environment side: offers requests, takes results.
   modport master (
      output in_valid, in_rand, in_count, out_ready,
      input  in_ready, out_valid, out_idx, out_err
   );

   // Mapper side.
   modport slave (
      input  in_valid, in_rand, in_count, out_ready,
      output in_ready, out_valid, out_idx, out_err
   );
endinterface

// File: rtl/unsat_index_mapper_m_recip_rom.sv
// Synchronous 1/m reciprocal ROM with read enable, addressed by m-1.
// Latency: one cycle from address to dat_o.
// Backpressure: en_i low holds the registered read data.
module m_recip_rom
   import unsat_index_mapper_pkg::*;
#(
   parameter int DEPTH      = 2048,
   parameter int WIDTH      = 32,
   parameter     TABLE_NAME = M_TABLE_NAME_DEFAULT
) (
   input  logic                     clk,
   input  logic                     en_i,
   input  logic [$clog2(DEPTH)-1:0] addr_i,
   output logic [WIDTH-1:0]         dat_o
);

   // Contents follow the same rule that generates the TABLE_NAME image, evaluated at
   // elaboration, so the model and the netlist never depend on an external file path.
   if ($bits(TABLE_NAME) < 8) begin : g_name_check
      $error("m_recip_rom: TABLE_NAME must name the reciprocal image");
   end

   logic [WIDTH-1:0] table_w [DEPTH];
   logic [WIDTH-1:0] dat_q;

   for (genvar i = 0; i < DEPTH; i++) begin : g_table
      assign table_w[i] = WIDTH'(recip_entry(i, WIDTH));
   end

   // Registered read; holds while the pipeline is stalled.
   always_ff @(posedge clk) begin
      if (en_i) begin
         dat_q <= table_w[addr_i];
      end
   end

   assign dat_o = dat_q;

endmodule

// File: rtl/unsat_index_mapper.sv
// Maps random word r and unsat count m to idx = r mod m via reciprocal multiply and one correction.
// Latency: 3 cycles from acceptance to out_valid; 1 request/cycle when unstalled.
// Backpressure: global stall, in_ready = !out_valid || out_ready; bubbles are not collapsed.
// Optional macro UNSAT_MAP_DIVZERO_DEBUG_EN adds the sticky m=0 flag and saturating m=0 counter.
module unsat_index_mapper
   import unsat_index_mapper_pkg::*;
#(
   parameter int BUFFER_DEPTH  = 2048,
   parameter int M_TABLE_WIDTH = 32,
   parameter int RAND_WIDTH    = 32,
   parameter     M_TABLE_NAME  = M_TABLE_NAME_DEFAULT
) (
   input  logic                clk,
   input  logic                rst,
   unsat_index_mapper_if.slave bus,
   input  logic                clear_debug_DIV_BY_ZERO,
   output logic                debug_DIV_BY_ZERO,
   output logic [15:0]         debug_zero_count
);

   localparam int CW = count_width(BUFFER_DEPTH);
   localparam int IW = index_width(BUFFER_DEPTH);
   localparam int RW = RAND_WIDTH;
   localparam int MW = M_TABLE_WIDTH;

   // A single correction step is only sufficient when r has no more bits than the reciprocal.
   if (RAND_WIDTH > M_TABLE_WIDTH) begin : g_width_check
      $error("unsat_index_mapper: RAND_WIDTH must not exceed M_TABLE_WIDTH");
   end

   typedef struct packed {
      logic [RW-1:0] r;
      logic [CW-1:0] m;
      req_flags_t    flags;
   } req_t;

   logic          advance;
   logic          accept;
   req_t          req_w;
   logic [IW-1:0] rom_addr_w;
   logic [MW-1:0] recip_w;

   logic          s0_vld_q, s1_vld_q, s2_vld_q, out_vld_q;
   req_t          s0_q, s1_q;
   logic [RW-1:0] s1_quo_q;
   logic [CW-1:0] s2_m_q;
   req_flags_t    s2_flags_q;
   logic [RW:0]   s2_rem_q;

   logic [RW+MW-1:0] prod_w;
   logic [RW-1:0]    quo_d;
   logic [RW:0]      qm_w;
   logic [RW:0]      rem_d;
   logic [RW:0]      m_ext_w;
   logic [RW:0]      idx_full_w;
   logic [IW-1:0]    out_idx_q, out_idx_d;
   logic             out_err_q, out_err_d;

   assign advance = !out_vld_q || bus.out_ready;
   assign accept  = bus.in_valid && advance;

   // Classify the incoming request and form the ROM address m-1 (don't-care for m=0).
   always_comb begin
      req_w.r             = bus.in_rand;
      req_w.m             = bus.in_count;
      req_w.flags.is_one  = (bus.in_count == CW'(1));
      req_w.flags.is_zero = (bus.in_count == '0);
      rom_addr_w          = IW'(bus.in_count - CW'(1));
   end

   m_recip_rom #(
      .DEPTH      (BUFFER_DEPTH),
      .WIDTH      (MW),
      .TABLE_NAME (M_TABLE_NAME)
   ) u_rom (
      .clk    (clk),
      .en_i   (advance),
      .addr_i (rom_addr_w),
      .dat_o  (recip_w)
   );

   // Quotient estimate: floor(r * ceil(2^MW/m) / 2^MW) is either floor(r/m) or one above it.
   always_comb begin
      prod_w = (RW+MW)'(s0_q.r) * (RW+MW)'(recip_w);
      quo_d  = RW'(prod_w >> MW);
   end

   // Signed remainder in RW+1 bits; lies in [-m, m-1] given the quotient estimate bound.
   always_comb begin
      qm_w  = (RW+1)'(s1_quo_q) * (RW+1)'(s1_q.m);
      rem_d = {1'b0, s1_q.r} - qm_w;
   end

   // Single correction step, then override for the m=1 and m=0 special cases.
   always_comb begin
      m_ext_w    = (RW+1)'(s2_m_q);
      idx_full_w = s2_rem_q;
      if (s2_rem_q[RW]) begin
         idx_full_w = s2_rem_q + m_ext_w;
      end else if (s2_rem_q >= m_ext_w) begin
         idx_full_w = s2_rem_q - m_ext_w;
      end
      out_idx_d = IW'(idx_full_w);
      out_err_d = 1'b0;
      if (s2_flags_q.is_zero) begin
         out_idx_d = '0;
         out_err_d = 1'b1;
      end else if (s2_flags_q.is_one) begin
         out_idx_d = '0;
      end
   end

   // Stage valids and the result register; all hold together when the output is blocked.
   always_ff @(posedge clk) begin
      if (rst) begin
         s0_vld_q  <= 1'b0;
         s1_vld_q  <= 1'b0;
         s2_vld_q  <= 1'b0;
         out_vld_q <= 1'b0;
         out_idx_q <= '0;
         out_err_q <= 1'b0;
      end else if (advance) begin
         s0_vld_q  <= accept;
         s1_vld_q  <= s0_vld_q;
         s2_vld_q  <= s1_vld_q;
         out_vld_q <= s2_vld_q;
         if (s2_vld_q) begin
            out_idx_q <= out_idx_d;
            out_err_q <= out_err_d;
         end
      end
   end

   // Stage payloads; qualified by the valids above, so they need no reset.
   always_ff @(posedge clk) begin
      if (advance) begin
         s0_q       <= req_w;
         s1_q       <= s0_q;
         s1_quo_q   <= quo_d;
         s2_m_q     <= s1_q.m;
         s2_flags_q <= s1_q.flags;
         s2_rem_q   <= rem_d;
      end
   end

   assign bus.in_ready  = advance;
   assign bus.out_valid = out_vld_q;
   assign bus.out_idx   = out_idx_q;
   assign bus.out_err   = out_err_q;

`ifdef UNSAT_MAP_DIVZERO_DEBUG_EN
   logic        zero_accept_w;
   logic        dbz_flag_q, dbz_flag_d;
   logic [15:0] dbz_cnt_q, dbz_cnt_d;

   assign zero_accept_w = accept && req_w.flags.is_zero;

   // Sticky flag (set beats clear) and saturating count of accepted m=0 requests.
   always_comb begin
      dbz_flag_d = dbz_flag_q;
      dbz_cnt_d  = dbz_cnt_q;
      if (zero_accept_w) begin
         dbz_flag_d = 1'b1;
      end else if (clear_debug_DIV_BY_ZERO) begin
         dbz_flag_d = 1'b0;
      end
      if (zero_accept_w && (dbz_cnt_q != 16'hFFFF)) begin
         dbz_cnt_d = dbz_cnt_q + 16'd1;
      end
   end

   // Debug state only clears on reset (the flag also via its clear input).
   always_ff @(posedge clk) begin
      if (rst) begin
         dbz_flag_q <= 1'b0;
         dbz_cnt_q  <= '0;
      end else begin
         dbz_flag_q <= dbz_flag_d;
         dbz_cnt_q  <= dbz_cnt_d;
      end
   end

   assign debug_DIV_BY_ZERO = dbz_flag_q;
   assign debug_zero_count  = dbz_cnt_q;
`else
   logic unused_clear;

   assign unused_clear      = clear_debug_DIV_BY_ZERO;
   assign debug_DIV_BY_ZERO = 1'b0;
   assign debug_zero_count  = '0;
`endif

endmodule

// File: tb/tb_unsat_index_mapper.sv
// Self-checking bench for unsat_index_mapper against a plain r mod m reference.
// Latency: checks the 3-cycle acceptance-to-result delay.
// Backpressure: drives random and held out_ready and checks in_ready, ordering and stability.
module tb_unsat_index_mapper;
   import unsat_index_mapper_pkg::*;

   localparam int DEPTH = 2048;
   localparam int RW    = 32;
   localparam int CW    = count_width(DEPTH);
   localparam int IW    = index_width(DEPTH);
`ifdef UNSAT_MAP_DIVZERO_DEBUG_EN
   localparam bit DBG_EN = 1'b1;
`else
   localparam bit DBG_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        clear;
   logic        dbg_flag;
   logic [15:0] dbg_cnt;
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clk = ~clk;

   unsat_index_mapper_if #(.RAND_WIDTH(RW), .BUFFER_DEPTH(DEPTH)) bus ();

   unsat_index_mapper #(
      .BUFFER_DEPTH  (DEPTH),
      .M_TABLE_WIDTH (32),
      .RAND_WIDTH    (RW),
      .M_TABLE_NAME  ("M_table_roundup.mem")
   ) dut (
      .clk                     (clk),
      .rst                     (rst),
      .bus                     (bus),
      .clear_debug_DIV_BY_ZERO (clear),
      .debug_DIV_BY_ZERO       (dbg_flag),
      .debug_zero_count        (dbg_cnt)
   );

   // Reference: the index the buffer read port should see.
   function automatic logic [31:0] ref_mod(input logic [31:0] r, input logic [CW-1:0] m);
      if (m == '0) return 32'd0;
      return r % 32'(m);
   endfunction

   // One isolated request with out_ready high; returns the result and cycles after acceptance.
   task automatic single_req(input logic [31:0] r, input logic [CW-1:0] m, input logic clr,
                             output logic [IW-1:0] idx, output logic err, output int lat);
      idx = 'x;
      err = 1'bx;
      lat = -1;
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_rand   = r;
      bus.in_count  = m;
      bus.out_ready = 1'b1;
      clear         = clr;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      clear        = 1'b0;
      for (int c = 1; c <= 8 && lat < 0; c++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) begin
            lat = c;
            idx = bus.out_idx;
            err = bus.out_err;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_rand = '0;
      bus.in_count = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
      n_tests++; if (bus.out_idx !== '0) begin n_fail++; $display("FAIL reset_out_idx: got %0d expected 0", bus.out_idx); end
      n_tests++; if (bus.out_err !== 1'b0) begin n_fail++; $display("FAIL reset_out_err: got %b expected 0", bus.out_err); end
      n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
      n_tests++; if (dbg_flag !== 1'b0) begin n_fail++; $display("FAIL reset_dbg_flag: got %b expected 0", dbg_flag); end
      n_tests++; if (dbg_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_dbg_cnt: got %0d expected 0", dbg_cnt); end
   endtask

   task automatic test_single();
      logic [IW-1:0] idx;
      logic          err;
      int            lat;
      logic [31:0]   r;
      logic [CW-1:0] m;
      single_req(32'd1000, CW'(7), 1'b0, idx, err, lat);
      n_tests++; if (lat != 3) begin n_fail++; $display("FAIL latency_1000_7: got %0d expected 3", lat); end
      n_tests++; if (idx !== IW'(6)) begin n_fail++; $display("FAIL idx_1000_7: got %0d expected 6", idx); end
      n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_1000_7: got %b expected 0", err); end
      single_req(32'hFFFF_FFFF, CW'(2048), 1'b0, idx, err, lat);
      n_tests++; if (idx !== IW'(2047) || lat != 3) begin n_fail++; $display("FAIL idx_max_2048: got %0d lat %0d expected 2047 lat 3", idx, lat); end
      single_req(32'hFFFF_FFFF, CW'(1), 1'b0, idx, err, lat);
      n_tests++; if (idx !== IW'(0) || err !== 1'b0) begin n_fail++; $display("FAIL idx_max_1: got %0d err %b expected 0 err 0", idx, err); end
      for (int i = 0; i < 6; i++) begin
         r = $urandom;
         m = CW'($urandom_range(1, DEPTH));
         single_req(r, m, 1'b0, idx, err, lat);
         n_tests++;
         if (idx !== IW'(ref_mod(r, m)) || err !== 1'b0 || lat != 3) begin
            n_fail++;
            $display("FAIL single_rand r=%0d m=%0d: got %0d err %b lat %0d expected %0d", r, m, idx, err, lat, ref_mod(r, m));
         end
      end
   endtask

   task automatic test_div_zero();
      logic [IW-1:0] idx;
      logic          err;
      int            lat;
      single_req(32'd5, '0, 1'b0, idx, err, lat);
      n_tests++; if (idx !== '0 || err !== 1'b1 || lat != 3) begin n_fail++; $display("FAIL div0_result: got idx %0d err %b lat %0d expected 0 1 3", idx, err, lat); end
      n_tests++; if (dbg_flag !== DBG_EN) begin n_fail++; $display("FAIL div0_flag_set: got %b expected %b", dbg_flag, DBG_EN); end
      n_tests++; if (dbg_cnt !== (DBG_EN ? 16'd1 : 16'd0)) begin n_fail++; $display("FAIL div0_count_1: got %0d expected %0d", dbg_cnt, DBG_EN ? 1 : 0); end
      single_req(32'd77, '0, 1'b1, idx, err, lat);
      n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL div0_second_err: got %b expected 1", err); end
      n_tests++; if (dbg_flag !== DBG_EN) begin n_fail++; $display("FAIL div0_set_beats_clear: got %b expected %b", dbg_flag, DBG_EN); end
      n_tests++; if (dbg_cnt !== (DBG_EN ? 16'd2 : 16'd0)) begin n_fail++; $display("FAIL div0_count_2: got %0d expected %0d", dbg_cnt, DBG_EN ? 2 : 0); end
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      #1;
      n_tests++; if (dbg_flag !== 1'b0) begin n_fail++; $display("FAIL div0_clear: got %b expected 0", dbg_flag); end
      n_tests++; if (dbg_cnt !== (DBG_EN ? 16'd2 : 16'd0)) begin n_fail++; $display("FAIL div0_count_kept: got %0d expected %0d", dbg_cnt, DBG_EN ? 2 : 0); end
   endtask

   task automatic test_back_to_back();
      logic [31:0]   exp_q[$];
      logic [31:0]   e;
      logic [31:0]   cur_r;
      logic [CW-1:0] cur_m;
      logic [IW-1:0] prev_idx;
      logic          prev_hold;
      int            sent, got, cyc;
      sent = 0; got = 0; cyc = 0; prev_hold = 1'b0; prev_idx = '0;
      while ((sent < 1000 || got < sent) && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         cur_r = $urandom;
         cur_m = CW'($urandom_range(1, DEPTH));
         bus.in_valid  = (sent < 1000) && ($urandom_range(0, 9) != 0);
         bus.in_rand   = cur_r;
         bus.in_count  = cur_m;
         bus.out_ready = ($urandom_range(0, 1) == 1);
         #1;
         n_tests++;
         if (bus.in_ready !== (!bus.out_valid || bus.out_ready)) begin
            n_fail++; $display("FAIL stream_in_ready: got %b out_valid %b out_ready %b", bus.in_ready, bus.out_valid, bus.out_ready);
         end
         if (prev_hold) begin
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.out_idx !== prev_idx) begin
               n_fail++; $display("FAIL stream_hold: got valid %b idx %0d expected valid 1 idx %0d", bus.out_valid, bus.out_idx, prev_idx);
            end
         end
         if (bus.out_valid && bus.out_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL stream_extra: got idx %0d expected no result", bus.out_idx);
            end else begin
               e = exp_q.pop_front();
               got++;
               if (bus.out_idx !== IW'(e) || bus.out_err !== 1'b0) begin
                  n_fail++; $display("FAIL stream_idx #%0d: got %0d err %b expected %0d err 0", got, bus.out_idx, bus.out_err, e);
               end
            end
         end
         prev_hold = bus.out_valid && !bus.out_ready;
         prev_idx  = bus.out_idx;
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(ref_mod(cur_r, cur_m));
            sent++;
         end
      end
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      n_tests++;
      if (sent != 1000 || got != 1000 || exp_q.size() != 0) begin
         n_fail++; $display("FAIL stream_count: got sent %0d received %0d pending %0d expected 1000 1000 0", sent, got, exp_q.size());
      end
   endtask

   task automatic test_stall();
      logic [31:0]   rs[4];
      logic [CW-1:0] ms[4];
      logic [31:0]   exp_q[$];
      logic [31:0]   e;
      int            acc, got;
      for (int i = 0; i < 4; i++) begin
         rs[i] = $urandom;
         ms[i] = CW'($urandom_range(2, DEPTH));
      end
      acc = 0;
      got = 0;
      for (int c = 0; c < 12 && acc < 4; c++) begin
         @(negedge clk);
         bus.in_valid  = 1'b1;
         bus.in_rand   = rs[acc];
         bus.in_count  = ms[acc];
         bus.out_ready = 1'b0;
         #1;
         if (bus.in_ready) begin
            exp_q.push_back(ref_mod(rs[acc], ms[acc]));
            acc++;
         end
      end
      n_tests++; if (acc != 4) begin n_fail++; $display("FAIL stall_accepted: got %0d expected 4", acc); end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_rand  = 32'hDEAD_BEEF;
         bus.in_count = CW'(3);
         #1;
         n_tests++;
         if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_idx !== IW'(exp_q[0])) begin
            n_fail++; $display("FAIL stall_hold: got in_ready %b valid %b idx %0d expected 0 1 %0d", bus.in_ready, bus.out_valid, bus.out_idx, exp_q[0]);
         end
      end
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 12 && got < 4; c++) begin
         #1;
         if (bus.out_valid) begin
            e = exp_q.pop_front();
            got++;
            n_tests++;
            if (bus.out_idx !== IW'(e)) begin
               n_fail++; $display("FAIL stall_drain #%0d: got %0d expected %0d", got, bus.out_idx, e);
            end
         end
         @(negedge clk);
      end
      n_tests++; if (got != 4) begin n_fail++; $display("FAIL stall_drain_count: got %0d expected 4", got); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.in_valid  = 1'b1;
         bus.in_rand   = $urandom;
         bus.in_count  = (i == 1) ? '0 : CW'($urandom_range(1, DEPTH));
         bus.out_ready = 1'b1;
      end
      @(negedge clk);
      n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_pre_valid: got %b expected 0", bus.out_valid); end
      rst = 1'b1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      bus.out_ready = 1'b0;
      #1;
      n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid: got %b expected 0", bus.out_valid); end
      n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: got %b expected 1", bus.in_ready); end
      n_tests++; if (dbg_flag !== 1'b0 || dbg_cnt !== 16'd0) begin n_fail++; $display("FAIL rstmid_debug: got flag %b count %0d expected 0 0", dbg_flag, dbg_cnt); end
      bus.out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         #1;
         n_tests++;
         if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_stale: got out_valid %b idx %0d expected no result", bus.out_valid, bus.out_idx);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_div_zero();
      test_back_to_back();
      test_stall();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
